sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's `sync_fifo`. It buffers `WIDTH`-bit words between a producer and a consumer in the same clock domain. On top of full/empty and per-request error pulses it adds:
- an occupancy count;
- programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow status with an explicit clear.

---
 rtl/sync_fifo_flags.sv | 149 ++++++++++++++
 tb/tb_sync_fifo_flags.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//
// Single-clock FIFO buffering WIDTH-bit words between a producer and a
// consumer in the same clock domain. Beyond full/empty it reports the
// occupancy count, programmable almost-full/almost-empty levels, one-cycle
// error pulses for rejected requests and sticky overflow/underflow status.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//   WIDTH      data word width
//   PTR_WIDTH  read/write pointer width
//   CNT_WIDTH  occupancy counter width (holds 0..DEPTH)
//   AF_LEVEL   almost_full_o asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL   almost_empty_o asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   wdata_i         write data
//   wr_en_i         write request
//   full_o          FIFO holds DEPTH words
//   almost_full_o   count >= AF_LEVEL
//   wr_error_o      one-cycle pulse after a rejected write
//   rdata_o         registered read data, holds until the next accepted read
//   rd_en_i         read request
//   empty_o         FIFO holds no words
//   almost_empty_o  count <= AE_LEVEL
//   rd_error_o      one-cycle pulse after a rejected read
//   count_o         current occupancy
//   ovf_o           sticky, set by any rejected write
//   unf_o           sticky, set by any rejected read
//   clr_err_i       clears ovf_o / unf_o (a same-cycle set wins)

module sync_fifo_flags #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH = $clog2(DEPTH + 1),
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 wr_en_i,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic                 wr_error_o,
  output logic [WIDTH-1:0]     rdata_o,
  input  logic                 rd_en_i,
  output logic                 empty_o,
  output logic                 almost_empty_o,
  output logic                 rd_error_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 ovf_o,
  output logic                 unf_o,
  input  logic                 clr_err_i
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AE_LEVEL);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wp;
  logic [PTR_WIDTH-1:0] rp;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 wa;
  logic                 ra;
  logic                 wr_reject;
  logic                 rd_reject;

  // Acceptance looks only at the registered flags, so a read in the same
  // cycle never makes room for a write at full (and vice versa at empty).
  assign wa        = wr_en_i & ~full_o;
  assign ra        = rd_en_i & ~empty_o;
  assign wr_reject = wr_en_i & full_o;
  assign rd_reject = rd_en_i & empty_o;

  assign count_o = cnt;

  // Next occupancy; the flags are registered from this value so they move
  // on the same edge as count_o.
  always_comb begin
    cnt_next = cnt;
    case ({wa, ra})
      2'b10:   cnt_next = cnt + CNT_WIDTH'(1);
      2'b01:   cnt_next = cnt - CNT_WIDTH'(1);
      default: cnt_next = cnt;
    endcase
  end

  // Storage array has no reset; stale contents are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (wa && !rst_i) begin
      mem[wp] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp             <= '0;
      rp             <= '0;
      cnt            <= '0;
      rdata_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      wr_error_o     <= 1'b0;
      rd_error_o     <= 1'b0;
      ovf_o          <= 1'b0;
      unf_o          <= 1'b0;
    end else begin
      if (wa) begin
        wp <= wp + PTR_WIDTH'(1);
      end
      if (ra) begin
        rdata_o <= mem[rp];
        rp      <= rp + PTR_WIDTH'(1);
      end

      cnt            <= cnt_next;
      full_o         <= (cnt_next == FULL_CNT);
      empty_o        <= (cnt_next == '0);
      almost_full_o  <= (cnt_next >= AF_CNT);
      almost_empty_o <= (cnt_next <= AE_CNT);

      wr_error_o <= wr_reject;
      rd_error_o <= rd_reject;

      // Set has priority over clear so no rejection can be lost.
      if (wr_reject) begin
        ovf_o <= 1'b1;
      end else if (clr_err_i) begin
        ovf_o <= 1'b0;
      end

      if (rd_reject) begin
        unf_o <= 1'b1;
      end else if (clr_err_i) begin
        unf_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags
//
// Directed bench for sync_fifo_flags with default parameters (DEPTH=16,
// WIDTH=8, AF_LEVEL=14, AE_LEVEL=2). Inputs change 1 ns after each rising
// edge and outputs are observed at that same point.

module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic       wr_en;
  logic       full;
  logic       almost_full;
  logic       wr_error;
  logic [7:0] rdata;
  logic       rd_en;
  logic       empty;
  logic       almost_empty;
  logic       rd_error;
  logic [4:0] count;
  logic       ovf;
  logic       unf;
  logic       clr_err;

  int total_checks = 0;
  int passed_checks = 0;

  sync_fifo_flags dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wdata_i        (wdata),
    .wr_en_i        (wr_en),
    .full_o         (full),
    .almost_full_o  (almost_full),
    .wr_error_o     (wr_error),
    .rdata_o        (rdata),
    .rd_en_i        (rd_en),
    .empty_o        (empty),
    .almost_empty_o (almost_empty),
    .rd_error_o     (rd_error),
    .count_o        (count),
    .ovf_o          (ovf),
    .unf_o          (unf),
    .clr_err_i      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  initial begin
    rst = 1'b1; wdata = 8'h55; wr_en = 1'b1; rd_en = 1'b1; clr_err = 1'b0;

    // Reset held two cycles with both requests active.
    tick();
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_count", count, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wr_error", wr_error, 0);
    check("rst_rd_error", rd_error, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    tick();
    check("idle_count", count, 0);
    check("idle_empty", empty, 1);

    // Fill with 0x00..0x0F.
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(i);
      tick();
      check("fill_count", count, i + 1);
      check("fill_almost_full", almost_full, (i + 1) >= 14);
      check("fill_full", full, (i + 1) == 16);
      check("fill_empty", empty, 0);
    end

    // Overflow attempt with 0xAA.
    wdata = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("ovf_wr_error", wr_error, 1);
    check("ovf_sticky", ovf, 1);
    check("ovf_count", count, 16);
    check("ovf_full", full, 1);
    tick();
    check("ovf_wr_error_pulse", wr_error, 0);
    check("ovf_stays", ovf, 1);
    check("ovf_count_hold", count, 16);

    // Drain in order; 0xAA must not appear.
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("drain_rdata", rdata, i);
      check("drain_count", count, 15 - i);
      check("drain_almost_empty", almost_empty, (15 - i) <= 2);
      check("drain_empty", empty, i == 15);
      check("drain_full", full, 0);
    end
    rd_en = 1'b0;

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_ovf", ovf, 0);

    // Underflow.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("unf_rd_error", rd_error, 1);
    check("unf_sticky", unf, 1);
    check("unf_rdata_hold", rdata, 8'h0F);
    check("unf_count", count, 0);
    check("unf_empty", empty, 1);
    tick();
    check("unf_rd_error_pulse", rd_error, 0);
    check("unf_stays", unf, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_unf", unf, 0);

    // Load five words, then stream 40 simultaneous write+read cycles.
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 8'(8'h20 + i);
      tick();
    end
    check("stream_preload_count", count, 5);
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wdata = 8'(8'h25 + k);
      tick();
      check("stream_count", count, 5);
      check("stream_rdata", rdata, 8'h20 + k);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stream_tail_rdata", rdata, 8'h48 + i);
      check("stream_tail_count", count, 4 - i);
    end
    rd_en = 1'b0;
    check("stream_empty", empty, 1);

    // Write+read while full: read wins, write is rejected.
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(8'h60 + i);
      tick();
    end
    check("full2_full", full, 1);
    wdata = 8'hBB; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("full_rw_count", count, 15);
    check("full_rw_rdata", rdata, 8'h60);
    check("full_rw_wr_error", wr_error, 1);
    check("full_rw_ovf", ovf, 1);
    check("full_rw_full", full, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("full_rw_clr", ovf, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("full_rw_drain", rdata, 8'h61 + i);
    end
    rd_en = 1'b0;
    check("full_rw_empty", empty, 1);

    // Write+read while empty: write wins, read is rejected.
    wdata = 8'hCC; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("empty_rw_count", count, 1);
    check("empty_rw_rd_error", rd_error, 1);
    check("empty_rw_unf", unf, 1);
    check("empty_rw_empty", empty, 0);
    check("empty_rw_rdata_hold", rdata, 8'h6F);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_rw_readback", rdata, 8'hCC);
    check("empty_rw_count0", count, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("empty_rw_clr", unf, 0);

    // Reset at count 9 discards everything.
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wdata = 8'(8'h70 + i);
      tick();
    end
    wr_en = 1'b0;
    check("midrst_pre_count", count, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_almost_empty", almost_empty, 1);
    check("midrst_rdata", rdata, 0);
    wdata = 8'h99; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("midrst_fresh_rdata", rdata, 8'h99);
    check("midrst_fresh_count", count, 0);

    // Clear in the same cycle as a rejected write: set wins.
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(8'h80 + i);
      tick();
    end
    clr_err = 1'b1;
    tick();
    wr_en = 1'b0;
    check("conflict_ovf", ovf, 1);
    check("conflict_wr_error", wr_error, 1);
    check("conflict_count", count, 16);
    tick();
    clr_err = 1'b0;
    check("conflict_clear_after", ovf, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
